// File: rtl/daq_pkg.sv
// daq_pkg: shared framing constants, scheduler state encoding and frame sizing
package daq_pkg;
   localparam logic [7:0] HDR_MARK = 8'hA5;
   localparam logic [7:0] TRL_MARK = 8'h5A;
   typedef enum logic [2:0] {IDLE, LOAD, WAIT, HDR0, HDR1, PAYLOAD, DRAIN, TRAIL} state_t;
   function automatic logic [18:0] frame_words(input logic [15:0] samples);
      return {samples, 3'b000};
   endfunction
endpackage

// File: rtl/next_enabled_ch.sv
// next_enabled_ch: next enabled channel above ch, or the lowest enabled one when first is set
module next_enabled_ch #(
   parameter int N = 6
) (
   input  logic [N-1:0] en,
   input  logic [3:0]   ch,
   input  logic         first,
   output logic [3:0]   next_ch,
   output logic         found
);
   always_comb begin
      next_ch = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--)
         if (en[i] && (first || 4'(i) > ch)) begin
            next_ch = 4'(i);
            found = 1'b1;
         end
   end
endmodule

// File: rtl/daq_frame_scheduler.sv
// daq_frame_scheduler: frames each enabled channel's ingress data into the egress FIFO,
// ascending channel order, with per-frame starvation abort
module daq_frame_scheduler import daq_pkg::*; #(
   parameter int N = 6,
   parameter int TIMEOUT = 65535
) (
   input  logic                init_clk,
   input  logic                reset_n_i,
   input  logic [N-1:0]        chan_en,
   input  logic [16*(N/2)-1:0] sample_count_value,
   input  logic [N-1:0]        ingress_fifo_empty,
   input  logic [16*N-1:0]     ingress_fifo_out,
   output logic [N-1:0]        ingress_fifo_rd_en,
   input  logic                egress_fifo_full,
   output logic [15:0]         egress_fifo_din,
   output logic                egress_fifo_wren,
   output logic [15:0]         event_cnt,
   output logic                busy,
   output logic [N-1:0]        err_timeout
);
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
   state_t state, state_n;
   logic [3:0] ch, ch_n, nxt_ch;
   logic [N-1:0] en_q, en_n, ch_oh;
   logic [18:0] cnt, cnt_n;
   logic [15:0] timer, timer_n, din_n, fifo_word, field;
   logic abort, abort_n, rd_q, rd, wr_n, evt_inc, err_set, found, empty_ch;

   next_enabled_ch #(.N(N)) u_next (
      .en(state == IDLE ? chan_en : en_q),
      .ch(ch),
      .first(state == IDLE),
      .next_ch(nxt_ch),
      .found(found)
   );

   assign ch_oh = {{(N-1){1'b0}}, 1'b1} << ch;
   assign empty_ch = |(ingress_fifo_empty & ch_oh);
   assign fifo_word = 16'(ingress_fifo_out >> {ch, 4'b0000});
   assign field = 16'(sample_count_value >> {ch[3:1], 4'b0000});
   assign rd = state == PAYLOAD && !empty_ch && !egress_fifo_full && cnt != '0;
   assign ingress_fifo_rd_en = rd ? ch_oh : '0;
   assign busy = state != IDLE;

   // a read issued last cycle has its data on ingress_fifo_out now and is written regardless of full
   always_comb begin
      state_n = state;
      ch_n = ch;
      en_n = en_q;
      cnt_n = cnt;
      timer_n = timer;
      abort_n = abort;
      wr_n = rd_q;
      din_n = rd_q ? fifo_word : egress_fifo_din;
      evt_inc = 1'b0;
      err_set = 1'b0;
      case (state)
         IDLE: if (|chan_en) begin
            en_n = chan_en;
            ch_n = nxt_ch;
            state_n = LOAD;
         end
         LOAD: begin
            cnt_n = frame_words(field);
            timer_n = '0;
            abort_n = 1'b0;
            state_n = WAIT;
         end
         WAIT: if (!empty_ch) state_n = HDR0;
         else if (timer == TO_LAST) begin
            abort_n = 1'b1;
            err_set = 1'b1;
            state_n = DRAIN;
         end else timer_n = timer + 16'd1;
         HDR0: if (!egress_fifo_full) begin
            wr_n = 1'b1;
            din_n = {HDR_MARK, 4'h0, ch};
            state_n = HDR1;
         end
         HDR1: if (!egress_fifo_full) begin
            wr_n = 1'b1;
            din_n = event_cnt;
            state_n = cnt == '0 ? DRAIN : PAYLOAD;
         end
         PAYLOAD: if (rd) begin
            cnt_n = cnt - 19'd1;
            timer_n = '0;
            state_n = cnt == 19'd1 ? DRAIN : PAYLOAD;
         end else if (empty_ch) begin
            if (timer == TO_LAST) begin
               abort_n = 1'b1;
               err_set = 1'b1;
               state_n = DRAIN;
            end else timer_n = timer + 16'd1;
         end
         DRAIN: state_n = TRAIL;
         TRAIL: if (!egress_fifo_full) begin
            wr_n = 1'b1;
            din_n = {TRL_MARK, abort, 3'b000, ch};
            ch_n = found ? nxt_ch : ch;
            evt_inc = !found;
            state_n = found ? LOAD : IDLE;
         end
      endcase
   end

   always_ff @(posedge init_clk or negedge reset_n_i)
      if (!reset_n_i) begin
         state <= IDLE;
         ch <= '0;
         en_q <= '0;
         cnt <= '0;
         timer <= '0;
         abort <= 1'b0;
         rd_q <= 1'b0;
         egress_fifo_din <= '0;
         egress_fifo_wren <= 1'b0;
         event_cnt <= '0;
         err_timeout <= '0;
      end else begin
         state <= state_n;
         ch <= ch_n;
         en_q <= en_n;
         cnt <= cnt_n;
         timer <= timer_n;
         abort <= abort_n;
         rd_q <= rd;
         egress_fifo_din <= din_n;
         egress_fifo_wren <= wr_n;
         event_cnt <= event_cnt + 16'(evt_inc);
         err_timeout <= err_timeout | (err_set ? ch_oh : '0);
      end
endmodule

// File: tb/tb_daq_frame_scheduler.sv
// tb_daq_frame_scheduler: ingress FIFO models, egress capture and a frame-level reference model
module tb_daq_frame_scheduler;
   localparam int N = 6;
   localparam int TO = 20;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] chan_en = '0;
   logic [47:0] counts = '0;
   logic [N-1:0] empty = '1;
   logic [16*N-1:0] fout = '0;
   logic [N-1:0] rd_en;
   logic full = 1'b0;
   logic [15:0] din, evt;
   logic wren, busy;
   logic [N-1:0] err;

   daq_frame_scheduler #(.N(N), .TIMEOUT(TO)) dut (
      .init_clk(clk),
      .reset_n_i(rst_n),
      .chan_en(chan_en),
      .sample_count_value(counts),
      .ingress_fifo_empty(empty),
      .ingress_fifo_out(fout),
      .ingress_fifo_rd_en(rd_en),
      .egress_fifo_full(full),
      .egress_fifo_din(din),
      .egress_fifo_wren(wren),
      .event_cnt(evt),
      .busy(busy),
      .err_timeout(err)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [N][128];
   int head [N];
   int tail [N];
   int exp_rem [N];
   logic [15:0] pend [N];
   logic [15:0] got [$];
   logic [15:0] exp_q [$];
   logic [N-1:0] err_exp = '0;
   logic [15:0] evt_exp = '0;
   int full_mode = 0, bad_rd = 0, cyc = 0, seq = 0;
   int checks = 0, passed = 0, fails = 0;

   // FIFO data is presented the cycle after the read; egress writes and flags update at posedge+1
   always begin
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) fout[16*c +: 16] = pend[c];
      if (wren) got.push_back(din);
      cyc++;
      full = full_mode == 1 ? ((cyc / 3) % 2 == 1) : full_mode == 2 ? ($urandom_range(9) < 3) : 1'b0;
      for (int c = 0; c < N; c++) empty[c] = head[c] == tail[c];
      #7;
      if ($countones(rd_en) > 1) bad_rd++;
      for (int c = 0; c < N; c++)
         if (rd_en[c]) begin
            if (head[c] == tail[c]) bad_rd++;
            else begin
               pend[c] = mem[c][head[c]];
               head[c]++;
            end
         end
   end

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp_v);
      end
   endtask

   task automatic fill(input int c, input int n);
      for (int i = 0; i < n; i++) begin
         mem[c][tail[c]] = {4'(c), 12'(seq)};
         seq++;
         tail[c]++;
      end
   endtask

   // frame stream from the rules: empty FIFO -> lone abort trailer; else header, min(avail, words) words, trailer
   task automatic model(input logic [N-1:0] en);
      for (int c = 0; c < N; c++) begin
         int avail, words, n;
         avail = tail[c] - head[c];
         words = 8 * int'(counts[16*(c/2) +: 16]);
         n = avail < words ? avail : words;
         if (!en[c]) exp_rem[c] = avail;
         else if (avail == 0) begin
            exp_q.push_back(16'h5A80 | 16'(c));
            err_exp[c] = 1'b1;
            exp_rem[c] = 0;
         end else begin
            exp_q.push_back(16'hA500 | 16'(c));
            exp_q.push_back(evt_exp);
            for (int i = 0; i < n; i++) exp_q.push_back(mem[c][head[c] + i]);
            exp_q.push_back((avail < words ? 16'h5A80 : 16'h5A00) | 16'(c));
            if (avail < words) err_exp[c] = 1'b1;
            exp_rem[c] = avail - n;
         end
      end
      evt_exp++;
   endtask

   task automatic run_event(input logic [N-1:0] en, input int fm, input string tag);
      int k, mm;
      @(negedge clk);
      got.delete();
      exp_q.delete();
      model(en);
      full_mode = fm;
      chan_en = en;
      k = 0;
      while (!busy && k < 10) begin @(negedge clk); k++; end
      chan_en = '0;
      k = 0;
      while (busy && k < 5000) begin @(negedge clk); k++; end
      check({tag, " done"}, 32'(busy), 0);
      full_mode = 0;
      repeat (3) @(negedge clk);
      check({tag, " len"}, got.size(), exp_q.size());
      mm = 0;
      foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) mm++;
      check({tag, " words"}, mm, 0);
      check({tag, " event_cnt"}, 32'(evt), 32'(evt_exp));
      check({tag, " err_timeout"}, 32'(err), 32'(err_exp));
      mm = 0;
      for (int c = 0; c < N; c++) if (tail[c] - head[c] != exp_rem[c]) mm++;
      check({tag, " remaining"}, mm, 0);
      check({tag, " bad reads"}, bad_rd, 0);
      for (int c = 0; c < N; c++) begin head[c] = 0; tail[c] = 0; end
   endtask

   initial begin
      int k, h0, w;
      repeat (3) @(negedge clk);
      check("reset rd_en", 32'(rd_en), 0);
      check("reset wren", 32'(wren), 0);
      check("reset din", 32'(din), 0);
      check("reset event_cnt", 32'(evt), 0);
      check("reset busy", 32'(busy), 0);
      check("reset err", 32'(err), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      counts = {3{16'd4}};
      fill(0, 40);
      fill(1, 40);
      run_event(6'b000011, 0, "two_ch");
      check("two_ch hdr0", 32'(got[0]), 32'h0000_A500);
      check("two_ch trl0", 32'(got[34]), 32'h0000_5A00);
      check("two_ch hdr1", 32'(got[35]), 32'h0000_A501);
      check("two_ch trl1", 32'(got[$]), 32'h0000_5A01);

      counts = {3{16'd1}};
      for (int c = 0; c < N; c++) fill(c, 10);
      run_event(6'b100100, 0, "sparse");
      check("sparse first hdr", 32'(got[0]), 32'h0000_A502);

      counts = {3{16'd4}};
      fill(3, 40);
      run_event(6'b001000, 1, "full_toggle");

      counts = {3{16'd4}};
      fill(1, 10);
      run_event(6'b000010, 0, "timeout");
      check("timeout trailer", 32'(got[$]), 32'h0000_5A81);
      check("timeout err1", 32'(err[1]), 1);

      counts = {16'd4, 16'd0, 16'd4};
      fill(2, 5);
      run_event(6'b000100, 0, "zero_cnt");
      check("zero_cnt trailer", 32'(got[$]), 32'h0000_5A02);

      for (int e = 0; e < 8; e++) begin
         for (int f = 0; f < N / 2; f++) counts[16*f +: 16] = 16'($urandom_range(6));
         for (int c = 0; c < N; c++) begin
            w = 8 * int'(counts[16*(c/2) +: 16]);
            fill(c, $urandom_range(3) == 0 ? 0 : $urandom_range(w + 4));
         end
         run_event(N'($urandom_range(63, 1)), $urandom_range(2), $sformatf("rand%0d", e));
      end

      counts = {3{16'd4}};
      fill(0, 40);
      @(negedge clk);
      chan_en = 6'b000001;
      k = 0;
      while (rd_en == '0 && k < 50) begin @(negedge clk); k++; end
      check("rst reached payload", 32'(rd_en != '0), 1);
      chan_en = '0;
      #2 rst_n = 1'b0;
      #1;
      check("async rst rd_en", 32'(rd_en), 0);
      check("async rst wren", 32'(wren), 0);
      check("async rst din", 32'(din), 0);
      check("async rst event_cnt", 32'(evt), 0);
      check("async rst busy", 32'(busy), 0);
      check("async rst err", 32'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      got.delete();
      h0 = head[0];
      repeat (20) @(negedge clk);
      check("post rst writes", got.size(), 0);
      check("post rst busy", 32'(busy), 0);
      check("post rst reads", head[0], h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
